icache_assoc: RTL

//  Parametrised set-associative instruction cache between datapath fetch and memory arbiter.

---
 rtl/icache_assoc.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/icache_assoc.sv
// Set-associative instruction cache: same-cycle hits, multi-word block refill FSM,
// true-LRU replacement, halt flush and saturating hit/miss counters.
module icache_assoc #(
  parameter int SETS     = 8,
  parameter int WAYS     = 2,
  parameter int BLKWORDS = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        halt,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int IW = $clog2(SETS);
  localparam int OB = $clog2(BLKWORDS);
  localparam int KW = (OB > 0) ? OB : 1;
  localparam int AW = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int LW = 30 - OB;
  localparam int TW = LW - IW;

  typedef enum logic {IDLE, FILL} state_t;

  state_t        state;
  logic [31:0]   data  [SETS][WAYS][BLKWORDS];
  logic [TW-1:0] tags  [SETS][WAYS];
  logic [WAYS-1:0] valid [SETS];
  logic [AW-1:0] age   [SETS][WAYS];
  logic [31:0]   fbuf  [BLKWORDS];
  logic [KW-1:0] k;
  logic [LW-1:0] mline;

  logic [LW-1:0] line;
  logic [IW-1:0] idx;
  logic [TW-1:0] tag;
  logic [KW-1:0] off;
  logic [IW-1:0] midx;
  logic [TW-1:0] mtag;
  logic          hit;
  logic [AW-1:0] hway;
  logic [AW-1:0] victim;
  logic          found;
  logic          fill_done;
  logic          touch_en;
  logic [IW-1:0] t_set;
  logic [AW-1:0] t_way;

  assign line = LW'(imemaddr >> (2 + OB));
  assign idx  = line[IW-1:0];
  assign tag  = line[LW-1:IW];
  assign off  = KW'((imemaddr >> 2) & 32'(BLKWORDS - 1));
  assign midx = mline[IW-1:0];
  assign mtag = mline[LW-1:IW];

  always_comb begin
    hit  = 1'b0;
    hway = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid[idx][w] && tags[idx][w] == tag) begin
        hit  = 1'b1;
        hway = AW'(w);
      end
    end
  end

  // Prefer the lowest invalid way; only a fully valid set falls back to the oldest way.
  always_comb begin
    victim = '0;
    found  = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!found && !valid[midx][w]) begin
        victim = AW'(w);
        found  = 1'b1;
      end
    end
    if (!found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age[midx][w] == AW'(WAYS - 1)) victim = AW'(w);
      end
    end
  end

  assign ihit      = (state == IDLE) && !halt && imemREN && hit;
  assign imemload  = ihit ? data[idx][hway][off] : '0;
  assign iREN      = (state == FILL);
  assign iaddr     = iREN ? ((32'(mline) << (OB + 2)) | (32'(k) << 2)) : '0;
  assign fill_done = (state == FILL) && !halt && !iwait && (k == KW'(BLKWORDS - 1));

  always_comb begin
    touch_en = ihit || fill_done;
    t_set    = fill_done ? midx : idx;
    t_way    = fill_done ? victim : hway;
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state      <= IDLE;
      k          <= '0;
      mline      <= '0;
      hit_count  <= '0;
      miss_count <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid[s] <= '0;
        // Ages start as a permutation so every set is a well-formed recency order.
        for (int w = 0; w < WAYS; w++) age[s][w] <= AW'(w);
      end
      for (int b = 0; b < BLKWORDS; b++) fbuf[b] <= '0;
    end else begin
      if (touch_en && WAYS > 1) begin
        for (int w = 0; w < WAYS; w++) begin
          if (AW'(w) == t_way)                   age[t_set][w] <= '0;
          else if (age[t_set][w] < age[t_set][t_way]) age[t_set][w] <= age[t_set][w] + AW'(1);
        end
      end
      case (state)
        IDLE: begin
          if (halt) begin
            for (int s = 0; s < SETS; s++) valid[s] <= '0;
          end else if (imemREN) begin
            if (hit) begin
              if (hit_count != '1) hit_count <= hit_count + 32'd1;
            end else begin
              mline <= line;
              k     <= '0;
              state <= FILL;
              if (miss_count != '1) miss_count <= miss_count + 32'd1;
            end
          end
        end
        FILL: begin
          if (halt) begin
            state <= IDLE;
          end else if (!iwait) begin
            fbuf[k] <= iload;
            if (fill_done) begin
              for (int b = 0; b < BLKWORDS; b++)
                data[midx][victim][b] <= (KW'(b) == k) ? iload : fbuf[b];
              tags[midx][victim]  <= mtag;
              valid[midx][victim] <= 1'b1;
              state               <= IDLE;
            end else begin
              k <= k + KW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
